serial_adder: RTL
=================

SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: N, default 8, operand width in bits (N >= 1).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  request to begin an addition; sampled on rising clk.
REQ-005 a0  input  N  first operand; sampled only when start is accepted.
REQ-006 a1  input  N  second operand; sampled only when start is accepted.
REQ-007 ci  input  1  carry-in; sampled only when start is accepted.
REQ-008 busy  output  1  high while an addition is in progress (RUN state).
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 sum  output  N  result bits; held stable from done until the next accepted start.
REQ-011 co  output  1  carry-out; held stable with sum.

Function
REQ-012 The block SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-013 start SHALL be accepted in IDLE or DONE: latch a0, a1, ci into internal shift registers; clear the bit counter; go to RUN.
REQ-014 start SHALL be ignored in RUN, with no effect on operands, counter, or outputs.
REQ-015 In RUN, each cycle SHALL process one bit, LSB first: sum bit i = a0[i] ^ a1[i] ^ c; carry c <= majority(a0[i], a1[i], c); the initial c is the latched ci.
REQ-016 The bit counter SHALL run 0..N-1; after the cycle that processes bit N-1, the FSM SHALL go to DONE.
REQ-017 Latency: if start is accepted at rising edge k, done SHALL be high during the cycle following edge k+N, for exactly one cycle.
REQ-018 In DONE, the FSM SHALL go to IDLE on the next edge unless start is high, in which case REQ-013 applies (back-to-back operation, no idle gap).
REQ-019 sum and co SHALL update only on the transition into DONE, so partial results are never visible on the outputs.
REQ-020 The result SHALL equal (a0 + a1 + ci) mod 2^N in sum, with the carry out of bit N-1 in co.
REQ-021 busy SHALL be high exactly in RUN; done SHALL be high exactly in DONE; they SHALL never be high together.
REQ-022 N = 1 SHALL work: RUN lasts exactly one cycle.

Reset
REQ-023 rst high SHALL immediately force: FSM to IDLE, counter 0, internal carry 0, shift registers 0, sum 0, co 0, busy 0, done 0.
REQ-024 rst asserted mid-RUN SHALL abort the operation and produce no done pulse.
REQ-025 After rst deasserts, the first start SHALL be accepted at the first rising edge on which it is sampled high.

Structure
REQ-026 Package serial_adder_pkg SHALL hold the FSM state typedef (IDLE/RUN/DONE).
REQ-027 Package serial_adder_pkg SHALL hold a counter-width function or constant derived as $clog2 of N, minimum 1.
REQ-028 The per-bit arithmetic SHALL be a separate combinational sub-module fa_slice (ports a, b, cin, s, cout), instantiated once.
REQ-029 The sequential logic SHALL reside in serial_adder only.

Verification (N=4 unless stated)
REQ-030 a0=4'b0011, a1=4'b0101, ci=0, start pulse -> busy for 4 cycles; then done one cycle with sum=4'b1000, co=0.
REQ-031 a0=4'b1111, a1=4'b0001, ci=0 -> sum=4'b0000, co=1; 4'b1111+4'b1111+ci=1 -> sum=4'b1111, co=1.
REQ-032 start re-asserted during RUN with a0=4'b0000, a1=4'b0000 -> ignored; the original result is delivered at the original done cycle.
REQ-033 rst pulsed at the 2nd RUN cycle -> all outputs 0 at once; no done pulse; the next start (4'b0010+4'b0010) -> sum=4'b0100, co=0.
REQ-034 start held high through DONE with new operands 4'b0001+4'b0001 -> busy again in the next cycle; second done exactly 5 cycles after the first done, with sum=4'b0010.
REQ-035 N=1 instance: 1+1+ci=1 -> done 1 cycle after acceptance, with sum=1, co=1.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared FSM state type and counter sizing for serial_adder
package serial_adder_pkg;

    // Controller states: waiting, shifting one bit per cycle, result pulse.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Bit counter width for an n-bit operand; a 1-bit operand still needs a 1-bit counter.
    function automatic int cnt_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/serial_adder_fa_slice.sv
// rtl/serial_adder_fa_slice.sv - single-bit full adder used by the serial datapath
module fa_slice (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    // Sum is the three-way parity, carry is the majority of the three inputs.
    always_comb begin
        s    = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder, LSB first, one bit per clock
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] a1,
    input  logic         ci,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] sum,
    output logic         co
);

    localparam int            CW       = cnt_width(N);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  a0_q,    a0_d;
    logic [N-1:0]  a1_q,    a1_d;
    logic [N-1:0]  acc_q,   acc_d;
    logic [N-1:0]  sum_q,   sum_d;
    logic          co_q,    co_d;

    logic          fa_s;
    logic          fa_cout;
    logic [N-1:0]  acc_next;

    // The operand shift registers always present the current bit at index 0.
    fa_slice u_fa (
        .a    (a0_q[0]),
        .b    (a1_q[0]),
        .cin  (carry_q),
        .s    (fa_s),
        .cout (fa_cout)
    );

    // Partial sum fills from the top so that after N shifts bit 0 lands at index 0.
    always_comb begin
        acc_next = N'({fa_s, acc_q} >> 1);
    end

    // Next-state and datapath control; a start in RUN falls through the defaults untouched.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        a0_d    = a0_q;
        a1_d    = a1_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        co_d    = co_q;

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a0_d    = a0;
                    a1_d    = a1;
                    carry_d = ci;
                    cnt_d   = '0;
                    acc_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a0_d    = a0_q >> 1;
                a1_d    = a1_q >> 1;
                carry_d = fa_cout;
                acc_d   = acc_next;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Results are published only here so partial sums never reach the outputs.
                    state_d = DONE;
                    cnt_d   = '0;
                    sum_d   = acc_next;
                    co_d    = fa_cout;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything immediately, aborting any run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            a0_q    <= '0;
            a1_q    <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            co_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            a0_q    <= a0_d;
            a1_q    <= a1_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            co_q    <= co_d;
        end
    end

    // Status flags decode directly from the state so they can never overlap.
    always_comb begin
        busy = (state_q == RUN);
        done = (state_q == DONE);
        sum  = sum_q;
        co   = co_q;
    end

endmodule
